// File: rtl/verin_pkg.sv
// verin_pkg: register map, bit positions and default widths for the tiller actuator PWM block
package verin_pkg;
  localparam int PWM_W_DEF   = 16;
  localparam int ANGLE_W_DEF = 12;
  localparam int ADDR_W_DEF  = 3;
  localparam int ADDR_FREQ    = 0;
  localparam int ADDR_DUTY    = 1;
  localparam int ADDR_BUTEE_G = 2;
  localparam int ADDR_BUTEE_D = 3;
  localparam int ADDR_CTRL    = 4;
  localparam int ADDR_STATUS  = 5;
  localparam int ADDR_ANGLE   = 6;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_SENS   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_FDC_G   = 0;
  localparam int ST_FDC_D   = 1;
  localparam int ST_BLOCKED = 2;
  localparam int ST_ACTIVE  = 3;
endpackage

// File: rtl/verin_pwm_core.sv
// verin_pwm_core: period counter, boundary-loaded shadows, duty compare and end-stop gating
module verin_pwm_core
  import verin_pkg::*;
#(
  parameter int PWM_W   = PWM_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic [PWM_W-1:0]   i_freq,
  input  logic [PWM_W-1:0]   i_duty,
  input  logic               i_sens,
  input  logic [ANGLE_W-1:0] i_angle,
  input  logic [ANGLE_W-1:0] i_butee_g,
  input  logic [ANGLE_W-1:0] i_butee_d,
  output logic               o_pwm,
  output logic               o_sens,
  output logic               o_sens_sh,
  output logic               o_blocked,
  output logic               o_run
);
  logic [PWM_W-1:0] r_cnt, r_freq_sh, r_duty_sh;
  logic             r_sens_sh;
  logic             w_last, w_bound;
  assign o_run     = i_en & (r_freq_sh >= PWM_W'(2));
  assign w_last    = r_cnt == r_freq_sh - PWM_W'(1);
  assign w_bound   = w_last | ~o_run;
  assign o_blocked = r_sens_sh ? (i_angle >= i_butee_d) : (i_angle <= i_butee_g);
  assign o_sens_sh = r_sens_sh;
  // shadows take the post-write register values, so a write landing on a boundary opens the new period
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_freq_sh <= '0;
      r_duty_sh <= '0;
      r_sens_sh <= 1'b0;
      o_pwm     <= 1'b0;
      o_sens    <= 1'b0;
    end else begin
      r_cnt  <= (o_run & ~w_last) ? r_cnt + PWM_W'(1) : '0;
      o_pwm  <= o_run & (r_cnt < r_duty_sh) & ~o_blocked;
      o_sens <= r_sens_sh;
      if (w_bound) begin
        r_freq_sh <= i_freq;
        r_duty_sh <= i_duty;
        r_sens_sh <= i_sens;
      end
    end
  end
endmodule

// File: rtl/verin_pwm_ctrl.sv
// verin_pwm_ctrl: Avalon-MM register file, angle capture, sticky end-stop flags and irq around the PWM core
module verin_pwm_ctrl
  import verin_pkg::*;
#(
  parameter int PWM_W   = PWM_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  input  logic [ANGLE_W-1:0] angle_in,
  input  logic               angle_valid,
  output logic               pwm_out,
  output logic               sens_out,
  output logic               irq
);
  logic [PWM_W-1:0]     r_freq, r_duty, w_freq_nxt, w_duty_nxt;
  logic [ANGLE_W-1:0]   r_butee_g, r_butee_d, r_angle;
  logic [2:0]           r_ctrl, w_ctrl_nxt;
  logic [2**ADDR_W-1:0] w_we;
  logic [3:0]           w_status;
  logic [31:0]          w_rdata;
  logic r_fdc_g, r_fdc_d, w_blocked, w_run, w_sens_sh, w_set_g, w_set_d, w_clr_g, w_clr_d, w_unused;
  assign w_unused   = ^avs_writedata;
  assign w_we       = {{(2**ADDR_W-1){1'b0}}, avs_write} << avs_address;
  assign w_freq_nxt = w_we[ADDR_FREQ] ? avs_writedata[PWM_W-1:0] : r_freq;
  assign w_duty_nxt = w_we[ADDR_DUTY] ? avs_writedata[PWM_W-1:0] : r_duty;
  assign w_ctrl_nxt = w_we[ADDR_CTRL] ? avs_writedata[2:0] : r_ctrl;
  assign w_set_g    = r_ctrl[CTRL_EN] & w_blocked & ~w_sens_sh;
  assign w_set_d    = r_ctrl[CTRL_EN] & w_blocked & w_sens_sh;
  assign w_clr_g    = w_we[ADDR_STATUS] & avs_writedata[ST_FDC_G];
  assign w_clr_d    = w_we[ADDR_STATUS] & avs_writedata[ST_FDC_D];
  // blocked/active report the drive actually being cut or running, so an idle block reads 0
  always_comb begin
    w_status              = '0;
    w_status[ST_FDC_G]    = r_fdc_g;
    w_status[ST_FDC_D]    = r_fdc_d;
    w_status[ST_BLOCKED]  = r_ctrl[CTRL_EN] & w_blocked;
    w_status[ST_ACTIVE]   = w_run & ~w_blocked;
  end
  assign w_rdata = avs_address == ADDR_W'(ADDR_FREQ)    ? 32'(r_freq)    :
                   avs_address == ADDR_W'(ADDR_DUTY)    ? 32'(r_duty)    :
                   avs_address == ADDR_W'(ADDR_BUTEE_G) ? 32'(r_butee_g) :
                   avs_address == ADDR_W'(ADDR_BUTEE_D) ? 32'(r_butee_d) :
                   avs_address == ADDR_W'(ADDR_CTRL)    ? 32'(r_ctrl)    :
                   avs_address == ADDR_W'(ADDR_STATUS)  ? 32'(w_status)  :
                   avs_address == ADDR_W'(ADDR_ANGLE)   ? 32'(r_angle)   : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq       <= '0;
      r_duty       <= '0;
      r_butee_g    <= '0;
      r_butee_d    <= '0;
      r_ctrl       <= '0;
      r_angle      <= '0;
      r_fdc_g      <= 1'b0;
      r_fdc_d      <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      r_freq    <= w_freq_nxt;
      r_duty    <= w_duty_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_butee_g <= w_we[ADDR_BUTEE_G] ? avs_writedata[ANGLE_W-1:0] : r_butee_g;
      r_butee_d <= w_we[ADDR_BUTEE_D] ? avs_writedata[ANGLE_W-1:0] : r_butee_d;
      r_angle   <= angle_valid ? angle_in : r_angle;
      r_fdc_g   <= w_set_g | (r_fdc_g & ~w_clr_g);
      r_fdc_d   <= w_set_d | (r_fdc_d & ~w_clr_d);
      irq       <= r_ctrl[CTRL_IRQ_EN] & (r_fdc_g | r_fdc_d);
      if (avs_read) avs_readdata <= w_rdata;
    end
  end
  verin_pwm_core #(.PWM_W(PWM_W), .ANGLE_W(ANGLE_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_freq    (w_freq_nxt),
    .i_duty    (w_duty_nxt),
    .i_sens    (w_ctrl_nxt[CTRL_SENS]),
    .i_angle   (r_angle),
    .i_butee_g (r_butee_g),
    .i_butee_d (r_butee_d),
    .o_pwm     (pwm_out),
    .o_sens    (sens_out),
    .o_sens_sh (w_sens_sh),
    .o_blocked (w_blocked),
    .o_run     (w_run)
  );
endmodule

// File: tb/tb_verin_pwm_ctrl.sv
// tb_verin_pwm_ctrl: table-driven register checks plus directed PWM, direction and end-stop sequences
module tb_verin_pwm_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [11:0] angle_in = '0;
  logic        angle_valid = 1'b0;
  logic        pwm_out, sens_out, irq;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  verin_pwm_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .angle_in      (angle_in),
    .angle_valid   (angle_valid),
    .pwm_out       (pwm_out),
    .sens_out      (sens_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic ang(input logic [11:0] v);
    @(negedge clk);
    angle_in = v;
    angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
  endtask

  task automatic sync_rise(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!pwm_out) break;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pwm_out) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic count_high(input string name, input int exp);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n += int'(pwm_out);
    end
    check(name, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [19:0] act20, exp20;
    logic [15:0] act16, exp16;
    logic s9, s10;
    bit found;
    vecs[0] = '{3'd0, 32'h0001_2345, 32'h2345};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF};
    vecs[2] = '{3'd2, 32'h0000_ABCD, 32'h0BCD};
    vecs[3] = '{3'd3, 32'h0000_1FFF, 32'h0FFF};
    vecs[4] = '{3'd4, 32'h0000_00F8, 32'h0};
    vecs[5] = '{3'd6, 32'h0000_0123, 32'h0};
    vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0};
    vecs[7] = '{3'd5, 32'h0000_00FF, 32'h0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_sens", 32'(sens_out), 0);
    check("rst_irq", 32'(irq), 0);
    for (int a = 0; a < 8; a++) chk_rd($sformatf("rst_rd[%0d]", a), 3'(a), 0);
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      chk_rd($sformatf("reg_rw[%0d]", i), vecs[i].addr, vecs[i].exp);
    end
    // basic 3/10 PWM, gauche, well away from both end-stops
    wr(3'd0, 10);
    wr(3'd1, 3);
    wr(3'd2, 12'h100);
    wr(3'd3, 12'hFFF);
    ang(12'h400);
    chk_rd("angle_rd", 3'd6, 12'h400);
    wr(3'd4, 32'h1);
    sync_rise("sync_3of10");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      act20[k] = pwm_out;
      exp20[k] = (k % 10) < 3;
    end
    check("pwm_3of10", 32'(act20), 32'(exp20));
    chk_rd("status_active", 3'd5, 32'h8);
    // mid-period DUTY/sens write must not disturb the current period
    sync_rise("sync_mid");
    wr(3'd1, 7);
    wr(3'd4, 32'h3);
    s9 = 1'b1;
    s10 = 1'b0;
    for (int k = 4; k < 20; k++) begin
      if (k > 4) @(negedge clk);
      act16[k-4] = pwm_out;
      exp16[k-4] = (k < 10) ? 1'b0 : ((k - 10) < 7);
      if (k == 9) s9 = sens_out;
      if (k == 10) s10 = sens_out;
    end
    check("pwm_mid_write", 32'(act16), 32'(exp16));
    check("sens_before_bound", 32'(s9), 0);
    check("sens_after_bound", 32'(s10), 1);
    // droite end-stop at exactly BUTEE_D
    wr(3'd4, 32'h7);
    wr(3'd3, 12'h800);
    sync_rise("sync_stop_d");
    ang(12'h800);
    check("pwm_still_high", 32'(pwm_out), 1);
    @(negedge clk);
    check("pwm_cut", 32'(pwm_out), 0);
    repeat (2) @(negedge clk);
    check("irq_set_d", 32'(irq), 1);
    chk_rd("status_blocked_d", 3'd5, 32'h6);
    wr(3'd5, 32'h2);
    chk_rd("status_set_wins", 3'd5, 32'h6);
    check("sens_droite", 32'(sens_out), 1);
    ang(12'h7FF);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm_out) begin
        found = 1'b1;
        break;
      end
    end
    check("pwm_resume", 32'(found), 1);
    wr(3'd5, 32'h2);
    chk_rd("status_w1c", 3'd5, 32'h8);
    check("irq_clear", 32'(irq), 0);
    chk_rd("angle_7ff", 3'd6, 12'h7FF);
    // degenerate periods and duty extremes
    wr(3'd0, 1);
    repeat (12) @(negedge clk);
    count_high("freq1_low", 0);
    chk_rd("status_freq1", 3'd5, 32'h0);
    wr(3'd0, 10);
    wr(3'd1, 0);
    repeat (12) @(negedge clk);
    count_high("duty0_low", 0);
    wr(3'd1, 20);
    repeat (12) @(negedge clk);
    count_high("duty20_high", 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm", 32'(pwm_out), 0);
    check("rst_mid_sens", 32'(sens_out), 0);
    check("rst_mid_irq", 32'(irq), 0);
    reset = 1'b0;
    chk_rd("rst_mid_ctrl", 3'd4, 0);
    chk_rd("rst_mid_freq", 3'd0, 0);
    // gauche end-stop at exactly BUTEE_G, then one LSB above it
    wr(3'd0, 10);
    wr(3'd1, 5);
    wr(3'd2, 12'h100);
    wr(3'd3, 12'hFFF);
    ang(12'h100);
    wr(3'd4, 32'h5);
    repeat (4) @(negedge clk);
    chk_rd("status_blocked_g", 3'd5, 32'h5);
    check("irq_set_g", 32'(irq), 1);
    ang(12'h101);
    repeat (2) @(negedge clk);
    chk_rd("status_g_sticky", 3'd5, 32'h9);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
